instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the single-cycle MIPS datapath. Holds the program counter and a word-addressed instruction memory. Each cycle it presents the current instruction, whose opcode field drives the main control decoder. It advances the PC by sequential increment, taken branch or jump, and a small boot/run/halt state machine gates the instruction valid flag.

## Interface
Parameters:
- IMEM_DEPTH, 64: instruction memory depth in 32-bit words; power of two, at least 2.
- RESET_PC, 32'h0000_0000: PC value loaded on reset; word-aligned.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- stall, input, 1: hold PC; no advance this cycle.
- branchTaken, input, 1: branch condition resolved true (branch control AND ALU zero).
- branchOffset, input, 32: sign-extended 16-bit immediate of the current instruction.
- jumpEn, input, 1: current instruction is a jump.
- jumpTarget, input, 26: instr[25:0] of the current instruction.
- imemWe, input, 1: instruction memory write enable, used for program load.
- imemWaddr, input, log2(IMEM_DEPTH): word address for the write.
- imemWdata, input, 32: word to write.
- pc, output, 32: current PC.
- pcPlus4, output, 32: pc + 4, modulo 2^32.
- instruction, output, 32: current instruction word.
- opcode, output, 6: instruction[31:26]; feeds the control decoder.
- instrValid, output, 1: instruction is a real fetch.
- halted, output, 1: fetch has stopped on a fault.

## Operation
- States:
  - BOOT: reset state; lasts exactly one cycle.
  - RUN: normal fetch.
  - HALT: fetch stopped; only reset exits.
- BOOT → RUN unconditionally on the next edge. The PC does not advance in BOOT.
- In RUN, the next PC is chosen by priority:
  - stall: hold PC.
  - jumpEn: {pcPlus4[31:28], jumpTarget, 2'b00}.
  - branchTaken: pcPlus4 + (branchOffset << 2), 32-bit wraparound, no overflow flag.
  - otherwise: pcPlus4.
- If jumpEn and branchTaken are both high, the jump wins.
- RUN → HALT when the candidate next PC has nextPC[1:0] != 0, or nextPC[31:2] >= IMEM_DEPTH. In that case the PC is not updated and keeps the last good value.
- A stalled cycle never causes a transition.
- Instruction read is combinational: imem[pc[log2(IMEM_DEPTH)+1:2]].
- instrValid = 1 only in RUN.
- When instrValid = 0, instruction is forced to 32'h0000_0000, so opcode is 6'b000000 (the datapath sees an sll nop).
- halted = 1 only in HALT.
- Memory write: imem[imemWaddr] <= imemWdata on the edge when imemWe = 1. Writes are permitted in any state, including during reset.
- Reset does not clear memory contents.

## Timing
- Reset values: pc = RESET_PC, pcPlus4 = RESET_PC + 4, state = BOOT, instrValid = 0, instruction = 0, opcode = 0, halted = 0.
- First valid instruction appears in the cycle after BOOT, at address RESET_PC.
- Next-PC selection uses same-cycle inputs, and the PC updates at the following edge: one cycle per instruction, zero fetch latency.
- Write to the word currently addressed: that cycle still shows the old word; the new word is visible in the cycle after the edge.
- Reset asserted mid-RUN or in HALT: at that edge state = BOOT and pc = RESET_PC; the branch, jump and stall inputs in that cycle are ignored.
- Reset has priority over every other input.
- PC wraparound: pcPlus4 of 32'hFFFF_FFFC is 0, but any PC beyond IMEM_DEPTH triggers HALT before it is used.

## Test plan
- Reset and sequential fetch. Load words 0..3 with 0x8C010000, 0xAC010004, 0x00221820, 0x10000000; pulse reset.
  - Cycle 0: instrValid = 0 and instruction = 0.
  - Cycles 1..4: pc = 0, 4, 8, C and opcode = 100011, 101011, 000000, 000100.
- Taken branch. At pc = 8, branchTaken = 1 and branchOffset = 32'hFFFF_FFFD → next pc = 0. At pc = 4, branchOffset = 2 → next pc = 0x10.
- Jump and priority. At pc = 4, jumpEn = 1 with jumpTarget = 26'h3 and branchTaken = 1 → next pc = 0xC (jump wins).
- Stall. Hold stall = 1 for 3 cycles at pc = 8 → pc stays 8 with instrValid = 1, then resumes at 0xC.
- Halt boundary (IMEM_DEPTH = 64).
  - Sequential fetch reaching pc = 0xFC → next edge gives halted = 1, instrValid = 0, pc = 0xFC, instruction = 0.
  - A branch to a misaligned target (offset giving pc[1:0] != 0 is unreachable by construction) is instead checked via RESET_PC = 0x100, which halts right after BOOT.
  - Reset from HALT → BOOT with pc = 0.
- Write/read collision. At pc = 4, write imemWaddr = 1 with 0x08000000 → that cycle opcode = 101011; after stall and re-fetch, opcode = 000010.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: datapath-side PC control and program-load port going in,
// current PC and instruction coming out.
`timescale 1ns/1ps
interface instr_fetch_if #(
    parameter int AW = 6
);
    logic          stall;
    logic          branchTaken;
    logic [31:0]   branchOffset;
    logic          jumpEn;
    logic [25:0]   jumpTarget;
    logic          imemWe;
    logic [AW-1:0] imemWaddr;
    logic [31:0]   imemWdata;
    logic [31:0]   pc;
    logic [31:0]   pcPlus4;
    logic [31:0]   instruction;
    logic [5:0]    opcode;
    logic          instrValid;
    logic          halted;

    modport master (
        output stall, branchTaken, branchOffset, jumpEn, jumpTarget,
               imemWe, imemWaddr, imemWdata,
        input  pc, pcPlus4, instruction, opcode, instrValid, halted
    );

    modport slave (
        input  stall, branchTaken, branchOffset, jumpEn, jumpTarget,
               imemWe, imemWaddr, imemWdata,
        output pc, pcPlus4, instruction, opcode, instrValid, halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch for the single-cycle MIPS datapath: PC register,
// word-addressed instruction memory and boot/run/halt sequencing.
//
// state | meaning
// BOOT  | one cycle after reset, PC held, no valid instruction
// RUN   | normal fetch, one instruction per cycle
// HALT  | next PC fell outside memory or was misaligned; only reset exits
`timescale 1ns/1ps
module instr_fetch #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.slave  bus
);
    localparam int          AW      = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   pc_plus4;
    logic [31:0]   cand_pc;
    logic          cand_ok;
    logic [AW-1:0] rd_idx;
    logic [31:0]   imem [IMEM_DEPTH];

    assign pc_plus4 = pc_q + 32'd4;
    assign rd_idx   = pc_q[AW+1:2];

    // Program load port; independent of reset so code can be loaded while held
    always_ff @(posedge clk) begin
        if (bus.imemWe) begin
            imem[bus.imemWaddr] <= bus.imemWdata;
        end
    end

    // Candidate next PC, jump taking priority over a taken branch
    always_comb begin
        cand_pc = pc_plus4;
        if (bus.jumpEn) begin
            cand_pc = {pc_plus4[31:28], bus.jumpTarget, 2'b00};
        end else if (bus.branchTaken) begin
            cand_pc = pc_plus4 + (bus.branchOffset << 2);
        end
    end

    // A target is usable only if word-aligned and inside the memory
    always_comb begin
        cand_ok = (cand_pc[1:0] == 2'b00) && ({2'b00, cand_pc[31:2]} < DEPTH_W);
    end

    // Next-state and next-PC; a bad target halts without disturbing the PC
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (!bus.stall) begin
                    if (cand_ok) begin
                        pc_d = cand_pc;
                    end else begin
                        state_d = HALT;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    // State and PC registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Outputs; outside RUN the datapath sees an all-zero word (sll nop)
    always_comb begin
        bus.pc          = pc_q;
        bus.pcPlus4     = pc_plus4;
        bus.instrValid  = (state_q == RUN);
        bus.halted      = (state_q == HALT);
        bus.instruction = (state_q == RUN) ? imem[rd_idx] : 32'h0000_0000;
        bus.opcode      = bus.instruction[31:26];
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// control/program-load traffic against a behavioural fetch model.
`timescale 1ns/1ps
module tb_instr_fetch;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst2 = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // behavioural model: memory image, PC, mode (0 boot, 1 run, 2 halt)
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc = 32'h0;
    int          m_mode = 0;

    instr_fetch_if #(.AW(6)) bus ();
    instr_fetch_if #(.AW(6)) bus2 ();

    instr_fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(rst), .bus(bus)
    );

    instr_fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0000_0100)) dut2 (
        .clk(clk), .reset(rst2), .bus(bus2)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.stall = 0; bus.branchTaken = 0; bus.branchOffset = 0;
        bus.jumpEn = 0; bus.jumpTarget = 0;
        bus.imemWe = 0; bus.imemWaddr = 0; bus.imemWdata = 0;
    endtask

    // advance the model with the currently driven inputs, then the clock
    task automatic tick();
        logic [31:0] p4, cand, np;
        int nm;
        p4 = m_pc + 32'd4;
        np = m_pc;
        nm = m_mode;
        if (rst) begin
            nm = 0; np = 32'h0;
        end else if (m_mode == 0) begin
            nm = 1;
        end else if (m_mode == 1 && !bus.stall) begin
            if (bus.jumpEn)           cand = {p4[31:28], bus.jumpTarget, 2'b00};
            else if (bus.branchTaken) cand = p4 + bus.branchOffset * 32'd4;
            else                      cand = p4;
            if ((cand % 4) != 0 || (cand / 4) >= DEPTH) nm = 2;
            else np = cand;
        end
        if (bus.imemWe) m_mem[bus.imemWaddr] = bus.imemWdata;
        m_pc = np;
        m_mode = nm;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0; tick();
    endtask

    task automatic test_reset();
        logic [31:0] prog [4];
        logic [5:0]  ops [4];
        prog[0] = 32'h8C01_0000; prog[1] = 32'hAC01_0004;
        prog[2] = 32'h0022_1820; prog[3] = 32'h1000_0000;
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000; ops[3] = 6'b000100;
        idle();
        rst = 1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.imemWe = 1;
            bus.imemWaddr = 6'(i);
            bus.imemWdata = (i < 4) ? prog[i] : 32'h0;
            tick();
        end
        idle();
        rst = 0;
        checks++; if (bus.instrValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.instrValid); end
        checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", bus.instruction); end
        checks++; if (bus.opcode !== 6'h0) begin errors++; $display("FAIL reset_opcode got %b want 0", bus.opcode); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", bus.halted); end
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.pc); end
        checks++; if (bus.pcPlus4 !== 32'h4) begin errors++; $display("FAIL reset_pcplus4 got %h want 4", bus.pcPlus4); end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, bus.pc, 4 * i); end
            checks++; if (bus.opcode !== ops[i]) begin errors++; $display("FAIL seq_opcode[%0d] got %b want %b", i, bus.opcode, ops[i]); end
            checks++; if (bus.instrValid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b want 1", i, bus.instrValid); end
            tick();
        end
    endtask

    task automatic test_branch();
        idle(); do_reset(); tick(); tick();
        checks++; if (bus.pc !== 32'h8) begin errors++; $display("FAIL br_setup_pc got %h want 8", bus.pc); end
        bus.branchTaken = 1; bus.branchOffset = 32'hFFFF_FFFD;
        tick(); idle();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL br_back_pc got %h want 0", bus.pc); end
        tick();
        bus.branchTaken = 1; bus.branchOffset = 32'h2;
        tick(); idle();
        checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL br_fwd_pc got %h want 10", bus.pc); end
        checks++; if (bus.pcPlus4 !== 32'h14) begin errors++; $display("FAIL br_fwd_pcplus4 got %h want 14", bus.pcPlus4); end
    endtask

    task automatic test_jump_priority();
        idle(); do_reset(); tick();
        bus.jumpEn = 1; bus.jumpTarget = 26'h3; bus.branchTaken = 1; bus.branchOffset = 32'h2;
        tick(); idle();
        checks++; if (bus.pc !== 32'hC) begin errors++; $display("FAIL jump_prio_pc got %h want c", bus.pc); end
    endtask

    task automatic test_stall();
        idle(); do_reset(); tick(); tick();
        bus.stall = 1;
        bus.jumpEn = 1; bus.jumpTarget = 26'h30;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.pc !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d] got %h want 8", i, bus.pc); end
            checks++; if (bus.instrValid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, bus.instrValid); end
        end
        idle();
        tick();
        checks++; if (bus.pc !== 32'hC) begin errors++; $display("FAIL stall_resume_pc got %h want c", bus.pc); end
    endtask

    task automatic test_reset_mid_run();
        idle(); do_reset(); tick(); tick();
        rst = 1; bus.jumpEn = 1; bus.jumpTarget = 26'h5; bus.branchTaken = 1;
        tick(); idle(); rst = 0;
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL midrst_pc got %h want 0", bus.pc); end
        checks++; if (bus.instrValid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus.instrValid); end
        tick();
        checks++; if (bus.pc !== 32'h0 || bus.instrValid !== 1'b1) begin errors++; $display("FAIL midrst_run got pc %h valid %b want pc 0 valid 1", bus.pc, bus.instrValid); end
    endtask

    task automatic test_halt_boundary();
        idle(); do_reset();
        repeat (63) tick();
        checks++; if (bus.pc !== 32'hFC || bus.instrValid !== 1'b1) begin errors++; $display("FAIL halt_last_pc got pc %h valid %b want pc fc valid 1", bus.pc, bus.instrValid); end
        tick();
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", bus.halted); end
        checks++; if (bus.instrValid !== 1'b0) begin errors++; $display("FAIL halt_valid got %b want 0", bus.instrValid); end
        checks++; if (bus.pc !== 32'hFC) begin errors++; $display("FAIL halt_pc got %h want fc", bus.pc); end
        checks++; if (bus.instruction !== 32'h0 || bus.opcode !== 6'h0) begin errors++; $display("FAIL halt_instr got %h want 0", bus.instruction); end
        bus.jumpEn = 1; bus.jumpTarget = 26'h1;
        tick(); idle();
        checks++; if (bus.halted !== 1'b1 || bus.pc !== 32'hFC) begin errors++; $display("FAIL halt_sticky got halted %b pc %h want 1 fc", bus.halted, bus.pc); end
        rst = 1; tick(); rst = 0;
        checks++; if (bus.pc !== 32'h0 || bus.halted !== 1'b0 || bus.instrValid !== 1'b0) begin errors++; $display("FAIL halt_reset got pc %h halted %b valid %b want 0 0 0", bus.pc, bus.halted, bus.instrValid); end
    endtask

    task automatic test_collision();
        idle(); do_reset(); tick();
        checks++; if (bus.opcode !== 6'b101011) begin errors++; $display("FAIL coll_pre_opcode got %b want 101011", bus.opcode); end
        bus.stall = 1; bus.imemWe = 1; bus.imemWaddr = 6'd1; bus.imemWdata = 32'h0800_0000;
        #1;
        checks++; if (bus.opcode !== 6'b101011) begin errors++; $display("FAIL coll_same_cycle got %b want 101011", bus.opcode); end
        tick(); idle();
        checks++; if (bus.pc !== 32'h4 || bus.opcode !== 6'b000010) begin errors++; $display("FAIL coll_refetch got pc %h opcode %b want 4 000010", bus.pc, bus.opcode); end
    endtask

    task automatic test_reset_pc_halt();
        bus2.stall = 0; bus2.branchTaken = 0; bus2.branchOffset = 0;
        bus2.jumpEn = 0; bus2.jumpTarget = 0;
        bus2.imemWe = 1; bus2.imemWaddr = 6'd0; bus2.imemWdata = 32'h2000_0001;
        rst2 = 1;
        @(posedge clk); #1;
        rst2 = 0; bus2.imemWe = 0;
        checks++; if (bus2.pc !== 32'h100 || bus2.instrValid !== 1'b0 || bus2.halted !== 1'b0) begin errors++; $display("FAIL rpc_boot got pc %h valid %b halted %b want 100 0 0", bus2.pc, bus2.instrValid, bus2.halted); end
        @(posedge clk); #1;
        checks++; if (bus2.pc !== 32'h100 || bus2.instrValid !== 1'b1) begin errors++; $display("FAIL rpc_run got pc %h valid %b want 100 1", bus2.pc, bus2.instrValid); end
        @(posedge clk); #1;
        checks++; if (bus2.halted !== 1'b1 || bus2.pc !== 32'h100 || bus2.instruction !== 32'h0) begin errors++; $display("FAIL rpc_halt got halted %b pc %h instr %h want 1 100 0", bus2.halted, bus2.pc, bus2.instruction); end
    endtask

    task automatic test_random();
        logic [31:0] e_instr;
        logic        e_valid;
        int          off;
        idle(); do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.stall       = ($urandom_range(0, 3) == 0);
            bus.jumpEn      = ($urandom_range(0, 7) == 0);
            bus.jumpTarget  = 26'($urandom_range(0, 72));
            bus.branchTaken = ($urandom_range(0, 3) == 0);
            off             = int'($urandom_range(0, 24)) - 12;
            bus.branchOffset = 32'(off);
            bus.imemWe      = ($urandom_range(0, 5) == 0);
            bus.imemWaddr   = 6'($urandom_range(0, DEPTH - 1));
            bus.imemWdata   = $urandom;
            rst = (m_mode == 2 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 99) == 0);
            e_valid = (m_mode == 1);
            e_instr = e_valid ? m_mem[(m_pc >> 2) % DEPTH] : 32'h0;
            checks++; if (bus.pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", cyc, bus.pc, m_pc); end
            checks++; if (bus.pcPlus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pcplus4 cyc %0d got %h want %h", cyc, bus.pcPlus4, m_pc + 32'd4); end
            checks++; if (bus.instruction !== e_instr) begin errors++; $display("FAIL rnd_instr cyc %0d got %h want %h", cyc, bus.instruction, e_instr); end
            checks++; if (bus.opcode !== e_instr[31:26]) begin errors++; $display("FAIL rnd_opcode cyc %0d got %b want %b", cyc, bus.opcode, e_instr[31:26]); end
            checks++; if (bus.instrValid !== e_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, bus.instrValid, e_valid); end
            checks++; if (bus.halted !== (m_mode == 2)) begin errors++; $display("FAIL rnd_halted cyc %0d got %b want %b", cyc, bus.halted, m_mode == 2); end
            tick();
        end
        rst = 0; idle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        idle();
        bus2.stall = 0; bus2.branchTaken = 0; bus2.branchOffset = 0;
        bus2.jumpEn = 0; bus2.jumpTarget = 0;
        bus2.imemWe = 0; bus2.imemWaddr = 0; bus2.imemWdata = 0;
        #2;
        test_reset();
        test_branch();
        test_jump_priority();
        test_stall();
        test_reset_mid_run();
        test_halt_boundary();
        test_collision();
        test_reset_pc_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
